wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the write-back data path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 alu_valid  input  1  ALU write-back request.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  DATA_W  ALU result.
REQ-007 alu_ready  output  1  ALU request accepted this cycle.
REQ-008 mem_valid  input  1  load-unit write-back request.
REQ-009 mem_rd  input  5  load destination register.
REQ-010 mem_data  input  DATA_W  load result.
REQ-011 mem_ready  output  1  load request accepted this cycle.
REQ-012 iss_valid  input  1  an instruction with a destination register issues this cycle.
REQ-013 iss_rd  input  5  destination register of the issuing instruction.
REQ-014 rs1_addr, rs2_addr  input  5 each  source registers of the instruction in decode.
REQ-015 rs1_busy, rs2_busy  output  1 each  source has a write-back pending (stall request).
REQ-016 RegWrite  output  1  register-file write enable.
REQ-017 WB_rd_addr  output  5  register-file write address.
REQ-018 WB_rd_data  output  DATA_W  register-file write data.

Function
REQ-019 A transfer occurs on a requester when valid and ready are both 1 at a rising edge; ready is combinational from the valid inputs and arbitration state, and is never asserted without the corresponding valid.
REQ-020 At most one of alu_ready/mem_ready is 1 in any cycle.
REQ-021 Only one requester valid: that requester is granted in the same cycle.
REQ-022 Both valid: round-robin; grant the requester not granted most recently; the 1-bit last-grant pointer updates on every transfer.
REQ-023 Write port is registered: transfer at edge N drives RegWrite=1, WB_rd_addr=rd and WB_rd_data=data for exactly the cycle following edge N; with no transfer, RegWrite=0 and addr/data hold their last values.
REQ-024 Transfers with rd=0 are accepted, but RegWrite stays 0 for that slot.
REQ-025 Sustained throughput is one transfer per cycle; with both requesters continuously valid, grants alternate ALU, MEM, ALU, ...
REQ-026 Scoreboard: 32 pending bits pend[31:0]; pend[0] is constant 0.
REQ-027 pend[iss_rd] is set at the edge where iss_valid=1 and iss_rd!=0.
REQ-028 pend[WB_rd_addr] is cleared at the edge where RegWrite=1, i.e. the same edge that writes the register file.
REQ-029 Set and clear of the same register at the same edge: set wins (a new producer overrides a completing one).
REQ-030 rs1_busy = pend[rs1_addr] and rs2_busy = pend[rs2_addr], combinational; address 0 is never busy.
REQ-031 A pending register is released for reading the cycle after its RegWrite cycle; there is no same-cycle bypass.
REQ-032 Data and rd are never modified between transfer and write; each accepted request produces exactly one write slot.

Reset
REQ-033 While rst=0, asynchronously: RegWrite=0, WB_rd_addr=0, WB_rd_data=0, pend all 0, and the last-grant pointer selects MEM as most recent, so the ALU wins the first contention.
REQ-034 While rst=0, alu_ready=0 and mem_ready=0 regardless of valid inputs.
REQ-035 A request accepted in the cycle rst falls is discarded; no RegWrite occurs after reset release until a new transfer.
REQ-036 Reset deassertion takes effect at the first rising edge after rst returns to 1, with no extra idle cycles.

Verification
REQ-037 Single ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> alu_ready=1 that cycle; next cycle RegWrite=1, WB_rd_addr=5, WB_rd_data=0x1234; the cycle after, RegWrite=0.
REQ-038 Contention: alu_valid and mem_valid held 1 for 4 cycles from reset (rd 1 and 2) -> grants ALU, MEM, ALU, MEM; RegWrite=1 for 4 consecutive cycles with addresses 1,2,1,2.
REQ-039 Scoreboard: iss_valid=1, iss_rd=7, then rs1_addr=7 -> rs1_busy=1 until mem write to x7; rs1_busy=0 the cycle after its RegWrite cycle.
REQ-040 Set/clear collision: RegWrite to x9 and iss_valid with iss_rd=9 in the same cycle -> pend[9] remains 1.
REQ-041 rd=0 request: mem_valid=1, mem_rd=0 -> mem_ready=1, RegWrite stays 0, rs1_addr=0 gives rs1_busy=0.
REQ-042 Reset mid-stream: rst=0 asserted while both requesters are valid with pend nonzero -> all outputs and pend 0 immediately; after release, the first contention grants ALU.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: round-robin between ALU and load unit onto one
// registered register-file write port, plus a pending-write scoreboard for decode stalls.
module wb_port_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              RegWrite,
    output logic [4:0]        WB_rd_addr,
    output logic [DATA_W-1:0] WB_rd_data
);

    logic              last_mem;   // 1: MEM was granted most recently
    logic [31:0]       pend;
    logic [31:0]       pend_nxt;
    logic              xfer;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign alu_ready = rst & alu_valid & (~mem_valid | last_mem);
    assign mem_ready = rst & mem_valid & (~alu_valid | ~last_mem);
    assign xfer      = alu_ready | mem_ready;
    assign sel_rd    = mem_ready ? mem_rd   : alu_rd;
    assign sel_data  = mem_ready ? mem_data : alu_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_mem   <= 1'b1;
            RegWrite   <= 1'b0;
            WB_rd_addr <= '0;
            WB_rd_data <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (xfer) begin
                last_mem <= mem_ready;
                // rd=0 is consumed silently; the port keeps its last address/data.
                if (sel_rd != 5'd0) begin
                    RegWrite   <= 1'b1;
                    WB_rd_addr <= sel_rd;
                    WB_rd_data <= sel_data;
                end
            end
        end
    end

    // Clear on the register-file write, then set from issue so a new producer wins.
    always_comb begin
        pend_nxt = pend;
        if (RegWrite)
            pend_nxt[WB_rd_addr] = 1'b0;
        if (iss_valid && iss_rd != 5'd0)
            pend_nxt[iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    assign rs1_busy = pend[rs1_addr];
    assign rs2_busy = pend[rs2_addr];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed test of wb_port_arbiter: single writes, contention, scoreboard, rd=0 and reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, iss_valid;
    logic [4:0]  alu_rd, mem_rd, iss_rd, rs1_addr, rs2_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rs1_busy, rs2_busy, RegWrite;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_data;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .WB_rd_addr(WB_rd_addr), .WB_rd_data(WB_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1; iss_valid = 1'b0;
        alu_rd = 5'd3; mem_rd = 5'd4; iss_rd = 5'd0;
        alu_data = 32'h0; mem_data = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;

        // reset state, readies held low despite valids
        #12;
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_addr", {27'd0, WB_rd_addr}, 32'd0);
        chk("rst_data", WB_rd_data, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        chk("rst_hold_regwrite", {31'd0, RegWrite}, 32'd0);
        rst = 1'b1;

        // single ALU write
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        chk("alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("alu_only_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("alu_wb_we", {31'd0, RegWrite}, 32'd1);
        chk("alu_wb_addr", {27'd0, WB_rd_addr}, 32'd5);
        chk("alu_wb_data", WB_rd_data, 32'h1234);
        tick();
        chk("alu_wb_off", {31'd0, RegWrite}, 32'd0);
        chk("alu_wb_hold_addr", {27'd0, WB_rd_addr}, 32'd5);
        chk("alu_wb_hold_data", WB_rd_data, 32'h1234);

        // contention from reset: ALU, MEM, ALU, MEM
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("cont_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_mem_ready", {31'd0, mem_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i == 3) begin
                alu_valid = 1'b0; mem_valid = 1'b0;
            end
            chk("cont_we", {31'd0, RegWrite}, 32'd1);
            chk("cont_addr", {27'd0, WB_rd_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_data", WB_rd_data, (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        tick();
        chk("cont_we_off", {31'd0, RegWrite}, 32'd0);

        // scoreboard: issue x7, load completes, released one cycle after write
        iss_valid = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        chk("sb_not_yet", {31'd0, rs1_busy}, 32'd0);
        tick();
        iss_valid = 1'b0;
        chk("sb_rs1_busy", {31'd0, rs1_busy}, 32'd1);
        chk("sb_rs2_busy", {31'd0, rs2_busy}, 32'd1);
        tick();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        #1;
        chk("sb_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("sb_busy_pre", {31'd0, rs1_busy}, 32'd1);
        tick();
        mem_valid = 1'b0;
        chk("sb_wb_addr", {27'd0, WB_rd_addr}, 32'd7);
        chk("sb_wb_data", WB_rd_data, 32'h77);
        chk("sb_busy_wb_cycle", {31'd0, rs1_busy}, 32'd1);
        tick();
        chk("sb_released", {31'd0, rs1_busy}, 32'd0);
        chk("sb_released_rs2", {31'd0, rs2_busy}, 32'd0);

        // set/clear collision on x9: set wins
        iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        chk("col_we", {31'd0, RegWrite}, 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("col_set_wins", {31'd0, rs1_busy}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h98;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("col_cleared", {31'd0, rs1_busy}, 32'd0);

        // rd=0 request: accepted, no write, x0 never busy
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
        #1;
        chk("rd0_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        mem_valid = 1'b0; iss_valid = 1'b0;
        chk("rd0_no_we", {31'd0, RegWrite}, 32'd0);
        chk("rd0_x0_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rd0_addr_hold", {27'd0, WB_rd_addr}, 32'd9);

        // reset mid-stream with pend nonzero and both requesters valid
        iss_valid = 1'b1; iss_rd = 5'd3; rs1_addr = 5'd3;
        tick();
        iss_valid = 1'b0;
        chk("mid_busy_before", {31'd0, rs1_busy}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
        tick();
        chk("mid_we_before", {31'd0, RegWrite}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_we", {31'd0, RegWrite}, 32'd0);
        chk("mid_addr", {27'd0, WB_rd_addr}, 32'd0);
        chk("mid_data", WB_rd_data, 32'd0);
        chk("mid_busy", {31'd0, rs1_busy}, 32'd0);
        chk("mid_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("mid_mem_ready", {31'd0, mem_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("post_alu_wins", {31'd0, alu_ready}, 32'd1);
        chk("post_mem_waits", {31'd0, mem_ready}, 32'd0);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("post_we", {31'd0, RegWrite}, 32'd1);
        chk("post_addr", {27'd0, WB_rd_addr}, 32'd4);
        chk("post_data", WB_rd_data, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
